// File: rtl/washing_machine_behavioral_if.sv
// Control/status bundle between the washing-machine sequencer and its surroundings.
// The master drives the user/timer inputs, and the sequencer (slave) returns the state and actuator decodes.
interface washing_machine_behavioral_if;
  logic       start;
  logic       cancel;
  logic       lid;
  logic       mode1;
  logic       mode2;
  logic       mode3;
  logic       mode4;
  logic       timer_done;
  logic       power_on;
  logic [2:0] state;
  logic [1:0] phase_sel;
  logic       soak_en;
  logic       wash_en;
  logic       rinse_en;
  logic       spin_en;
  logic       timer_enable;

  modport master (
    output start, cancel, lid, mode1, mode2, mode3, mode4, timer_done, power_on,
    input  state, phase_sel, soak_en, wash_en, rinse_en, spin_en, timer_enable
  );

  modport slave (
    input  start, cancel, lid, mode1, mode2, mode3, mode4, timer_done, power_on,
    output state, phase_sel, soak_en, wash_en, rinse_en, spin_en, timer_enable
  );
endinterface

// File: rtl/washing_machine_behavioral.sv
// Washing-machine phase sequencer: IDLE -> CHECK -> mode-dependent SOAK/WASH/RINSE/SPIN chain.
// Phase timing lives in an external timer; all outputs decode the registered state plus power_on/lid.
module washing_machine_behavioral (
  input  logic                          clk,
  input  logic                          rst_n,
  washing_machine_behavioral_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SOAK  = 3'd2,
    S_WASH  = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    M_NONE   = 3'd0,
    M_QUICK  = 3'd1,
    M_NORMAL = 3'd2,
    M_HEAVY  = 3'd3,
    M_SPIN   = 3'd4
  } mode_t;

  state_t     r_state;
  mode_t      r_mode;
  logic       w_run;
  logic       w_any_mode;
  logic       w_start_ok;
  logic       w_adv;
  logic [1:0] w_phase_sel;

  // mode1 wins over mode2 over mode3 over mode4
  function automatic mode_t f_pick_mode(input logic m1, input logic m2,
                                        input logic m3, input logic m4);
    if (m1)      return M_QUICK;
    else if (m2) return M_NORMAL;
    else if (m3) return M_HEAVY;
    else if (m4) return M_SPIN;
    else         return M_NONE;
  endfunction

  assign w_run      = bus.power_on & ~bus.lid;
  assign w_any_mode = bus.mode1 | bus.mode2 | bus.mode3 | bus.mode4;
  assign w_start_ok = bus.start & w_run & w_any_mode;
  assign w_adv      = w_run & bus.timer_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= M_NONE;
    end else if (bus.cancel) begin
      r_state <= S_IDLE;
      r_mode  <= M_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state <= S_CHECK;
            r_mode  <= f_pick_mode(bus.mode1, bus.mode2, bus.mode3, bus.mode4);
          end
        end
        S_CHECK: begin
          case (r_mode)
            M_QUICK:          r_state <= S_WASH;
            M_NORMAL,
            M_HEAVY:          r_state <= S_SOAK;
            M_SPIN:           r_state <= S_SPIN;
            default: begin
              r_state <= S_IDLE;
              r_mode  <= M_NONE;
            end
          endcase
        end
        // Paused (power off or lid open) phases simply ignore timer_done
        S_SOAK:  if (w_adv) r_state <= S_WASH;
        S_WASH:  if (w_adv) r_state <= S_RINSE;
        S_RINSE: if (w_adv) r_state <= S_SPIN;
        S_SPIN: begin
          if (w_adv) begin
            r_state <= S_IDLE;
            r_mode  <= M_NONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_mode  <= M_NONE;
        end
      endcase
    end
  end

  always_comb begin
    w_phase_sel = 2'd0;
    case (r_state)
      S_SOAK:  w_phase_sel = 2'd0;
      S_WASH:  w_phase_sel = 2'd1;
      S_RINSE: w_phase_sel = 2'd2;
      S_SPIN:  w_phase_sel = 2'd3;
      default: w_phase_sel = 2'd0;
    endcase
  end

  assign bus.state        = r_state;
  assign bus.phase_sel    = w_phase_sel;
  assign bus.soak_en      = (r_state == S_SOAK)  & w_run;
  assign bus.wash_en      = (r_state == S_WASH)  & w_run;
  assign bus.rinse_en     = (r_state == S_RINSE) & w_run;
  assign bus.spin_en      = (r_state == S_SPIN)  & w_run;
  assign bus.timer_enable = ((r_state == S_SOAK) | (r_state == S_WASH) |
                             (r_state == S_RINSE) | (r_state == S_SPIN)) & w_run;

endmodule

// File: tb/tb_washing_machine_behavioral.sv
// Bench for washing_machine_behavioral: directed scenarios plus random stimulus, every cycle
// compared against a phase-list reference model of the washing-machine rules.
module tb_washing_machine_behavioral;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  // reference model: current state code plus the list of phases for the latched mode
  int   m_state;
  int   m_seq[$];
  int   m_idx;

  washing_machine_behavioral_if w_if ();

  washing_machine_behavioral dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_seq.delete();
    m_idx = 0;
  endtask

  task automatic model_step();
    bit run;
    run = w_if.power_on && !w_if.lid;
    if (!rst_n || w_if.cancel) begin
      model_reset();
    end else if (m_state == 0) begin
      if (w_if.start && run && (w_if.mode1 || w_if.mode2 || w_if.mode3 || w_if.mode4)) begin
        if (w_if.mode1)                    m_seq = '{3, 4, 5};
        else if (w_if.mode2 || w_if.mode3) m_seq = '{2, 3, 4, 5};
        else                               m_seq = '{5};
        m_state = 1;
      end
    end else if (m_state == 1) begin
      m_idx   = 0;
      m_state = m_seq[0];
    end else if (run && w_if.timer_done) begin
      m_idx++;
      if (m_idx < m_seq.size()) m_state = m_seq[m_idx];
      else                      model_reset();
    end
  endtask

  task automatic check_all(input string tag);
    bit run;
    int ps;
    run = w_if.power_on && !w_if.lid;
    ps  = (m_state >= 2) ? m_state - 2 : 0;
    chk({tag, "/state"},     8'(w_if.state),        8'(m_state));
    chk({tag, "/phase_sel"}, 8'(w_if.phase_sel),    8'(ps));
    chk({tag, "/soak_en"},   8'(w_if.soak_en),      8'(m_state == 2 && run));
    chk({tag, "/wash_en"},   8'(w_if.wash_en),      8'(m_state == 3 && run));
    chk({tag, "/rinse_en"},  8'(w_if.rinse_en),     8'(m_state == 4 && run));
    chk({tag, "/spin_en"},   8'(w_if.spin_en),      8'(m_state == 5 && run));
    chk({tag, "/timer_en"},  8'(w_if.timer_enable), 8'(m_state >= 2 && run));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    repeat (n) cycle(tag);
  endtask

  task automatic pulse_done(input string tag);
    w_if.timer_done = 1'b1;
    cycle(tag);
    w_if.timer_done = 1'b0;
  endtask

  task automatic start_pulse(input string tag);
    w_if.start = 1'b1;
    cycle(tag);
    w_if.start = 1'b0;
  endtask

  task automatic set_mode(input logic [3:0] m);
    {w_if.mode4, w_if.mode3, w_if.mode2, w_if.mode1} = m;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    model_reset();
    rst_n           = 1'b0;
    w_if.start      = 1'b0;
    w_if.cancel     = 1'b0;
    w_if.lid        = 1'b0;
    w_if.timer_done = 1'b0;
    w_if.power_on   = 1'b1;
    set_mode(4'b0000);

    #2;
    check_all("reset");
    #10 rst_n = 1'b1;
    idle_cycles(2, "idle");

    // Quick: 0 -> 1 -> 3 -> 4 -> 5 -> 0
    set_mode(4'b0001);
    start_pulse("quick");
    chk("quick_check", 8'(w_if.state), 8'd1);
    set_mode(4'b0000);
    cycle("quick");
    chk("quick_wash", 8'(w_if.state), 8'd3);
    idle_cycles(3, "quick");
    pulse_done("quick");
    chk("quick_rinse", 8'(w_if.state), 8'd4);
    idle_cycles(2, "quick");
    pulse_done("quick");
    chk("quick_spin", 8'(w_if.state), 8'd5);
    pulse_done("quick");
    chk("quick_end", 8'(w_if.state), 8'd0);

    // Normal: 1,2,3,4,5,0 with phase_sel 0..3
    set_mode(4'b0010);
    start_pulse("normal");
    cycle("normal");
    chk("normal_soak", 8'(w_if.state), 8'd2);
    for (int i = 0; i < 4; i++) begin
      chk("normal_psel", 8'(w_if.phase_sel), 8'(i));
      idle_cycles(2, "normal");
      pulse_done("normal");
    end
    chk("normal_end", 8'(w_if.state), 8'd0);

    // Spin-only: 1,5,0
    set_mode(4'b1000);
    start_pulse("spinonly");
    cycle("spinonly");
    chk("spinonly_spin", 8'(w_if.state), 8'd5);
    pulse_done("spinonly");
    chk("spinonly_end", 8'(w_if.state), 8'd0);

    // Priority: mode1 beats mode4, goes to WASH
    set_mode(4'b1001);
    start_pulse("prio");
    cycle("prio");
    chk("prio_wash", 8'(w_if.state), 8'd3);

    // Power cut in WASH with timer_done pulses
    w_if.power_on = 1'b0;
    for (int i = 0; i < 30; i++) begin
      w_if.timer_done = (i % 3 == 0);
      cycle("powercut");
    end
    w_if.timer_done = 1'b0;
    chk("powercut_state", 8'(w_if.state), 8'd3);
    chk("powercut_ten", 8'(w_if.timer_enable), 8'd0);
    w_if.power_on = 1'b1;
    #1;
    chk("power_back_ten", 8'(w_if.timer_enable), 8'd1);
    pulse_done("power_back");
    chk("power_back_rinse", 8'(w_if.state), 8'd4);

    // Lid opened in RINSE
    w_if.lid = 1'b1;
    #1;
    chk("lid_rinse_en", 8'(w_if.rinse_en), 8'd0);
    pulse_done("lid");
    idle_cycles(3, "lid");
    chk("lid_hold", 8'(w_if.state), 8'd4);
    w_if.lid = 1'b0;
    cycle("lid_close");
    chk("lid_resume_en", 8'(w_if.rinse_en), 8'd1);
    pulse_done("lid_close");
    pulse_done("lid_close");
    chk("lid_end", 8'(w_if.state), 8'd0);

    // start with lid open in IDLE is ignored
    set_mode(4'b0010);
    w_if.lid   = 1'b1;
    w_if.start = 1'b1;
    idle_cycles(3, "lid_start");
    chk("lid_start_idle", 8'(w_if.state), 8'd0);
    w_if.start = 1'b0;
    w_if.lid   = 1'b0;

    // cancel in SOAK together with timer_done
    start_pulse("cancel");
    cycle("cancel");
    chk("cancel_soak", 8'(w_if.state), 8'd2);
    w_if.cancel     = 1'b1;
    w_if.timer_done = 1'b1;
    cycle("cancel");
    w_if.cancel     = 1'b0;
    w_if.timer_done = 1'b0;
    chk("cancel_idle", 8'(w_if.state), 8'd0);

    // start held across the end of a cycle restarts after one IDLE cycle
    set_mode(4'b1000);
    w_if.start = 1'b1;
    cycle("held");
    cycle("held");
    pulse_done("held");
    chk("held_idle", 8'(w_if.state), 8'd0);
    cycle("held");
    chk("held_restart", 8'(w_if.state), 8'd1);
    w_if.start  = 1'b0;
    w_if.cancel = 1'b1;
    cycle("held");
    w_if.cancel = 1'b0;

    // Random stimulus against the model
    for (int i = 0; i < 500; i++) begin
      w_if.start      = ($urandom_range(3) == 0);
      w_if.cancel     = ($urandom_range(40) == 0);
      w_if.lid        = ($urandom_range(7) == 0);
      w_if.power_on   = ($urandom_range(7) != 0);
      w_if.timer_done = ($urandom_range(2) == 0);
      w_if.mode1      = ($urandom_range(3) == 0);
      w_if.mode2      = ($urandom_range(3) == 0);
      w_if.mode3      = ($urandom_range(3) == 0);
      w_if.mode4      = ($urandom_range(3) == 0);
      cycle("rand");
    end
    w_if.start      = 1'b0;
    w_if.lid        = 1'b0;
    w_if.power_on   = 1'b1;
    w_if.timer_done = 1'b0;
    w_if.cancel     = 1'b1;
    cycle("rand_flush");
    w_if.cancel     = 1'b0;

    // Asynchronous reset mid-SPIN
    set_mode(4'b1000);
    start_pulse("rst_spin");
    cycle("rst_spin");
    chk("rst_in_spin", 8'(w_if.state), 8'd5);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_spin_en", 8'(w_if.spin_en), 8'd0);
    cycle("rst_low");
    #2 rst_n = 1'b1;
    idle_cycles(3, "post_rst");
    chk("post_rst_idle", 8'(w_if.state), 8'd0);
    start_pulse("post_rst");
    chk("post_rst_check", 8'(w_if.state), 8'd1);
    cycle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/washing_machine_behavioral.md
WASHING_MACHINE_BEHAVIORAL -- requirements
Module: washing_machine_behavioral

Interface
REQ-001 SHALL have no parameters; the phase sequence is fixed and phase durations belong to the external multi_phase_timer.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  level start request, sampled in IDLE.
REQ-005 cancel  input  1  abort cycle, return to IDLE.
REQ-006 lid  input  1  1 = lid open, 0 = closed.
REQ-007 mode1/mode2/mode3/mode4  input  1 each  Quick/Normal/Heavy/Spin-only select.
REQ-008 timer_done  input  1  one-cycle pulse from timer: current phase time expired.
REQ-009 power_on  input  1  1 = mains present.
REQ-010 state  output  3  current state code.
REQ-011 phase_sel  output  2  phase index to timer: 0 soak, 1 wash, 2 rinse, 3 spin.
REQ-012 soak_en/wash_en/rinse_en/spin_en  output  1 each  actuator enables.
REQ-013 timer_enable  output  1  timer count enable.

Function
REQ-014 State codes SHALL be: 0 IDLE, 1 CHECK, 2 SOAK, 3 WASH, 4 RINSE, 5 SPIN; codes 6-7 are illegal and SHALL go to IDLE on the next edge.
REQ-015 Mode SHALL be latched on leaving IDLE, with mode1 > mode2 > mode3 > mode4 priority; the latched mode SHALL be held until return to IDLE.
REQ-016 IDLE->CHECK SHALL occur when start=1, power_on=1, lid=0 and at least one mode bit is 1; otherwise the FSM SHALL stay in IDLE.
REQ-017 CHECK SHALL last exactly one cycle, then go to the first phase of the latched mode: Quick -> WASH; Normal/Heavy -> SOAK; Spin-only -> SPIN.
REQ-018 Phase order SHALL be: Quick WASH->RINSE->SPIN; Normal/Heavy SOAK->WASH->RINSE->SPIN; Spin-only SPIN.
REQ-019 In a phase state, the FSM SHALL advance on the edge where timer_done=1 and timer_enable=1; SPIN + timer_done SHALL go to IDLE.
REQ-020 Pause: with power_on=0 or lid=1, the FSM SHALL hold its state and ignore timer_done; it SHALL resume the same phase when both conditions clear.
REQ-021 cancel=1 SHALL force IDLE on the next edge from any state and SHALL take priority over timer_done and pause.
REQ-022 phase_sel SHALL decode from state: SOAK 0, WASH 1, RINSE 2, SPIN 3, all other states 0.
REQ-023 Each x_en SHALL be 1 only when state equals its phase, power_on=1 and lid=0.
REQ-024 timer_enable SHALL be 1 only in states 2-5 with power_on=1 and lid=0.
REQ-025 All outputs SHALL be Moore/combinational decodes of the registered state and the power_on/lid inputs, with no extra latency.
REQ-026 start held high across the cycle end SHALL NOT cause a restart until start is sampled again in IDLE; IDLE SHALL accept a new start one cycle after entry.
REQ-027 washing_machine_dataflow SHALL be cycle-identical to this module on every output.

Reset
REQ-028 rst_n=0 SHALL immediately force state=0, phase_sel=0, all x_en=0, timer_enable=0 and latched mode=none, independent of clk.
REQ-029 Reset asserted mid-cycle SHALL abort the cycle; after release the FSM SHALL wait in IDLE for a new start.

Verification
REQ-030 Quick: mode1=1, start pulse, lid=0, power_on=1, timer_done pulsed 3 times -> state 0,1,3,4,5,0; wash_en, rinse_en, spin_en each high only in their phase.
REQ-031 Normal (mode2) -> state sequence 1,2,3,4,5,0; phase_sel 0,1,2,3; Spin-only (mode4) -> 1,5,0.
REQ-032 Power cut in WASH: power_on=0 for 30 cycles with timer_done pulsed -> state stays 3, timer_enable=0, wash_en=0; power_on=1 -> timer_enable=1, and the next timer_done gives state 4.
REQ-033 Lid opened in RINSE -> state holds 4, rinse_en=0; lid=0 resumes; start with lid=1 in IDLE -> state stays 0.
REQ-034 cancel=1 in SOAK together with a timer_done pulse -> state 0 next edge, all enables 0.
REQ-035 rst_n=0 asserted mid-SPIN between clock edges -> outputs go to 0 before the next edge.
